// File: rtl/readout_ctrl_pkg.sv
// Shared types and FIFO word layout for the readout sequencer.
// The layout helpers take NSAMP_W so every user derives identical field offsets.
package readout_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LANE_W    = 72;
    localparam int PIPE_LAT  = 4;
    localparam int FREQ_LSB  = 0;
    localparam int PHASE_LSB = 32;
    localparam int NSAMP_LSB = 64;

    function automatic int outsel_lsb(input int nsamp_w);
        return 64 + nsamp_w;
    endfunction

    function automatic int phrst_bit(input int nsamp_w);
        return 66 + nsamp_w;
    endfunction

    function automatic int mode_bit(input int nsamp_w);
        return 67 + nsamp_w;
    endfunction

    function automatic int fifo_w(input int nsamp_w);
        return 68 + nsamp_w;
    endfunction

    // Cycles left after the load cycle; a zero nsamp still plays for one clock.
    function automatic logic [31:0] dur_m1(input logic [31:0] nsamp);
        return (nsamp == 32'd0) ? 32'd0 : nsamp - 32'd1;
    endfunction

endpackage

// File: rtl/readout_phase_lane.sv
// One DDS lane: registers freq*LANE_IDX and the shared base phase, then sums them.
// The output phase only updates on the pipelined load strobe and holds otherwise.
module readout_phase_lane
    import readout_ctrl_pkg::*;
#(
    parameter int LANE_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] freq,
    input  logic [31:0] base,
    input  logic        ld,
    output logic [31:0] phase
);

    logic [31:0] fi_q;
    logic [31:0] base_q;
    logic [31:0] phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fi_q    <= '0;
            base_q  <= '0;
            phase_q <= '0;
        end else begin
            fi_q   <= freq * 32'(LANE_IDX);
            base_q <= base;
            if (ld) begin
                phase_q <= base_q + fi_q;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/readout_ctrl_v3.sv
// Readout sequencer: pops command words from a FWFT FIFO and drives N_DDS lane control words.
// Optional build macro READOUT_CTRL_TSTAMP_EN adds tstamp_o / tstamp_valid_o.
//
// state | meaning
// IDLE  | no word playing; pops as soon as the FIFO is non-empty
// RUN   | holding a word for max(nsamp,1) clocks; reloads, replays or returns to IDLE at cnt==0
module readout_ctrl_v3
    import readout_ctrl_pkg::*;
#(
    parameter int N_DDS   = 16,
    parameter int NSAMP_W = 16,
    parameter int FIFO_W  = 68 + NSAMP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      fifo_rd_en_o,
    input  logic                      fifo_empty_i,
    input  logic [FIFO_W-1:0]         fifo_dout_i,
    output logic [N_DDS*LANE_W-1:0]   dds_ctrl_o,
    output logic [1:0]                outsel_o,
    output logic                      busy_o
`ifdef READOUT_CTRL_TSTAMP_EN
    ,
    output logic [31:0]               tstamp_o,
    output logic                      tstamp_valid_o
`endif
);

    localparam int OUTSEL_LSB = outsel_lsb(NSAMP_W);
    localparam int PHRST_BIT  = phrst_bit(NSAMP_W);
    localparam int MODE_BIT   = mode_bit(NSAMP_W);

    logic [31:0]        in_freq;
    logic [31:0]        in_phase;
    logic [NSAMP_W-1:0] in_nsamp;
    logic [1:0]         in_outsel;
    logic               in_phrst;
    logic               in_mode;

    assign in_freq   = fifo_dout_i[FREQ_LSB +: 32];
    assign in_phase  = fifo_dout_i[PHASE_LSB +: 32];
    assign in_nsamp  = fifo_dout_i[NSAMP_LSB +: NSAMP_W];
    assign in_outsel = fifo_dout_i[OUTSEL_LSB +: 2];
    assign in_phrst  = fifo_dout_i[PHRST_BIT];
    assign in_mode   = fifo_dout_i[MODE_BIT];

    state_t             state_q;
    state_t             state_nxt;
    logic [NSAMP_W-1:0] cnt_q;
    logic [31:0]        cnt_n_q;
    logic [31:0]        t0_q;

    logic [31:0]        h_freq;
    logic [31:0]        h_phase;
    logic [NSAMP_W-1:0] h_nsamp;
    logic [1:0]         h_outsel;
    logic               h_phrst;
    logic               h_mode;

    logic               pop;
    logic               replay;
    logic               load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if ((cnt_q == '0) && fifo_empty_i && !h_mode) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pops are gated by rst so a reset landing mid-word never consumes a FIFO entry.
    always_comb begin
        pop    = 1'b0;
        replay = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: pop = !fifo_empty_i;
                RUN: begin
                    if (cnt_q == '0) begin
                        if (!fifo_empty_i) begin
                            pop = 1'b1;
                        end else if (h_mode) begin
                            replay = 1'b1;
                        end
                    end
                end
                default: begin
                    pop    = 1'b0;
                    replay = 1'b0;
                end
            endcase
        end
        load         = pop | replay;
        fifo_rd_en_o = pop;
        busy_o       = (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cnt_n_q  <= '0;
            t0_q     <= '0;
            h_freq   <= '0;
            h_phase  <= '0;
            h_nsamp  <= '0;
            h_outsel <= '0;
            h_phrst  <= 1'b0;
            h_mode   <= 1'b0;
        end else begin
            cnt_n_q <= cnt_n_q + 32'(N_DDS);
            if (pop) begin
                h_freq   <= in_freq;
                h_phase  <= in_phase;
                h_nsamp  <= in_nsamp;
                h_outsel <= in_outsel;
                h_phrst  <= in_phrst;
                h_mode   <= in_mode;
                cnt_q    <= NSAMP_W'(dur_m1(32'(in_nsamp)));
            end else if (replay) begin
                cnt_q <= NSAMP_W'(dur_m1(32'(h_nsamp)));
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - NSAMP_W'(1);
            end
            if (load) begin
                t0_q <= cnt_n_q;
            end
        end
    end

    // Stage 2: shared base phase and lane increment; stage 3 lives partly in the lanes.
    logic [PIPE_LAT-1:0] ld_pipe;
    logic [31:0]         freq_d2;
    logic [31:0]         base_d2;
    logic [31:0]         pinc_d2;
    logic [1:0]          outsel_d2;
    logic [31:0]         pinc_d3;
    logic [1:0]          outsel_d3;
    logic [31:0]         pinc_q;
    logic [1:0]          outsel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_pipe   <= '0;
            freq_d2   <= '0;
            base_d2   <= '0;
            pinc_d2   <= '0;
            outsel_d2 <= '0;
            pinc_d3   <= '0;
            outsel_d3 <= '0;
            pinc_q    <= '0;
            outsel_q  <= '0;
        end else begin
            ld_pipe   <= {ld_pipe[PIPE_LAT-2:0], load};
            freq_d2   <= h_freq;
            base_d2   <= h_phrst ? h_phase : (h_phase + h_freq * t0_q);
            pinc_d2   <= h_freq * 32'(N_DDS);
            outsel_d2 <= h_outsel;
            pinc_d3   <= pinc_d2;
            outsel_d3 <= outsel_d2;
            if (ld_pipe[PIPE_LAT-2]) begin
                pinc_q   <= pinc_d3;
                outsel_q <= outsel_d3;
            end
        end
    end

`ifdef READOUT_CTRL_TSTAMP_EN
    logic [31:0] t0_d2;
    logic [31:0] t0_d3;
    logic [31:0] tstamp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            t0_d2    <= '0;
            t0_d3    <= '0;
            tstamp_q <= '0;
        end else begin
            t0_d2 <= t0_q;
            t0_d3 <= t0_d2;
            if (ld_pipe[PIPE_LAT-2]) begin
                tstamp_q <= t0_d3;
            end
        end
    end

    assign tstamp_o       = tstamp_q;
    assign tstamp_valid_o = ld_pipe[PIPE_LAT-1];
`endif

    logic [31:0] lane_phase [N_DDS];

    for (genvar g = 0; g < N_DDS; g++) begin : g_lane
        readout_phase_lane #(
            .LANE_IDX(g)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .freq  (freq_d2),
            .base  (base_d2),
            .ld    (ld_pipe[PIPE_LAT-2]),
            .phase (lane_phase[g])
        );
        assign dds_ctrl_o[g*LANE_W +: LANE_W] = {7'h00, ld_pipe[PIPE_LAT-1], lane_phase[g], pinc_q};
    end

    assign outsel_o = outsel_q;

endmodule

// File: tb/tb_readout_ctrl_v3.sv
// Directed bench for readout_ctrl_v3 with a FWFT FIFO model and pop/sync recorders.
module tb_readout_ctrl_v3;

    localparam int N  = 16;
    localparam int NW = 16;
    localparam int FW = 68 + NW;
    localparam int LW = 72;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_rd_en;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_dout;
    logic [N*LW-1:0]   dds_ctrl;
    logic [1:0]        outsel;
    logic              busy;
`ifdef READOUT_CTRL_TSTAMP_EN
    logic [31:0]       tstamp;
    logic              tstamp_valid;
`endif

    readout_ctrl_v3 #(.N_DDS(N), .NSAMP_W(NW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_empty_i (fifo_empty),
        .fifo_dout_i  (fifo_dout),
        .dds_ctrl_o   (dds_ctrl),
        .outsel_o     (outsel),
        .busy_o       (busy)
`ifdef READOUT_CTRL_TSTAMP_EN
        ,
        .tstamp_o       (tstamp),
        .tstamp_valid_o (tstamp_valid)
`endif
    );

    always #5 clk = ~clk;

    logic [FW-1:0]   mem [256];
    logic [7:0]      wr_ptr = 8'd0;
    logic [7:0]      rd_ptr = 8'd0;
    int              cyc = 0;
    logic [31:0]     cn_model = 32'd0;
    int              pop_cyc [256];
    logic [31:0]     pop_cn [256];
    int              ns = 0;
    int              sync_cyc [256];
    logic [1:0]      sync_outsel [256];
    logic [N*LW-1:0] sync_dds [256];
    logic [31:0]     sync_ts [256];
    int              total = 0;
    int              bad = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) cn_model <= 32'd0;
        else     cn_model <= cn_model + 32'd16;
        if (fifo_rd_en) begin
            pop_cyc[rd_ptr] <= cyc;
            pop_cn[rd_ptr]  <= cn_model;
            rd_ptr          <= rd_ptr + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en && fifo_empty) begin
            bad = bad + 1;
            $display("FAIL pop_while_empty: rd_en=1 with empty=1 at cycle %0d", cyc);
        end
        if (dds_ctrl[64] && ns < 256) begin
            sync_cyc[ns]    = cyc;
            sync_outsel[ns] = outsel;
            sync_dds[ns]    = dds_ctrl;
`ifdef READOUT_CTRL_TSTAMP_EN
            sync_ts[ns]     = tstamp;
`else
            sync_ts[ns]     = 32'd0;
`endif
            ns = ns + 1;
        end
`ifdef READOUT_CTRL_TSTAMP_EN
        if (tstamp_valid !== dds_ctrl[64]) begin
            bad = bad + 1;
            $display("FAIL tstamp_valid_align: got %0b want %0b", tstamp_valid, dds_ctrl[64]);
        end
`endif
    end

    function automatic logic [FW-1:0] mk(input logic mode, input logic phrst, input logic [1:0] os,
                                         input logic [NW-1:0] nsamp, input logic [31:0] phase,
                                         input logic [31:0] freq);
        return {mode, phrst, os, nsamp, phase, freq};
    endfunction

    function automatic logic [31:0] ph(input logic [N*LW-1:0] d, input int i);
        return d[i*LW+32 +: 32];
    endfunction

    function automatic logic [31:0] pi(input logic [N*LW-1:0] d, input int i);
        return d[i*LW +: 32];
    endfunction

    task automatic push(input logic [FW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset();
        push(mk(1'b0, 1'b1, 2'd2, 16'd5, 32'h0, 32'h100));
        repeat (3) begin
            @(negedge clk);
            total++;
            if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctrl: rd_en=%0b busy=%0b want 0 0", fifo_rd_en, busy);
            end
            total++;
            if (dds_ctrl !== '0 || outsel !== 2'd0) begin
                bad++;
                $display("FAIL reset_outputs: dds=%0h outsel=%0d want 0", dds_ctrl, outsel);
            end
        end
        total++;
        if (rd_ptr !== 8'd0) begin
            bad++;
            $display("FAIL reset_no_pop: pops=%0d want 0", rd_ptr);
        end
    endtask

    task automatic test_single();
        int p0 = int'(rd_ptr);
        int s0 = ns;
        int nb = 0;
        rst = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (busy) nb++;
        end
        #1;
        total++;
        if (int'(rd_ptr) - p0 != 1) begin bad++; $display("FAIL single_pops: got %0d want 1", int'(rd_ptr) - p0); end
        total++;
        if (nb != 5) begin bad++; $display("FAIL single_busy: got %0d want 5", nb); end
        total++;
        if (ns - s0 != 1) begin bad++; $display("FAIL single_syncs: got %0d want 1", ns - s0); end
        else begin
            total++;
            if (sync_cyc[s0] - pop_cyc[p0] != 4) begin
                bad++; $display("FAIL single_latency: got %0d want 4", sync_cyc[s0] - pop_cyc[p0]);
            end
            total++;
            if (pi(sync_dds[s0], 0) !== 32'h1000) begin
                bad++; $display("FAIL single_pinc: got %0h want 1000", pi(sync_dds[s0], 0));
            end
            total++;
            if (ph(sync_dds[s0], 3) !== 32'h300) begin
                bad++; $display("FAIL single_lane3: got %0h want 300", ph(sync_dds[s0], 3));
            end
            total++;
            if (ph(sync_dds[s0], 0) !== 32'h0 || ph(sync_dds[s0], 15) !== 32'hF00) begin
                bad++; $display("FAIL single_lane0_15: got %0h %0h want 0 f00", ph(sync_dds[s0], 0), ph(sync_dds[s0], 15));
            end
            total++;
            if (sync_outsel[s0] !== 2'd2) begin
                bad++; $display("FAIL single_outsel: got %0d want 2", sync_outsel[s0]);
            end
        end
        total++;
        if (busy !== 1'b0 || dds_ctrl[64] !== 1'b0 || pi(dds_ctrl, 3) !== 32'h1000 || dds_ctrl[71:65] !== 7'h0) begin
            bad++; $display("FAIL single_hold: busy=%0b sync=%0b pinc=%0h pad=%0h want 0 0 1000 0",
                            busy, dds_ctrl[64], pi(dds_ctrl, 3), dds_ctrl[71:65]);
        end
    endtask

    task automatic test_back_to_back();
        int p0 = int'(rd_ptr);
        int s0 = ns;
        int nb = 0;
        push(mk(1'b0, 1'b1, 2'd1, 16'd3, 32'h1000, 32'h10));
        push(mk(1'b0, 1'b1, 2'd3, 16'd7, 32'h0, 32'h20));
        repeat (16) begin
            @(negedge clk);
            if (busy) nb++;
        end
        #1;
        total++;
        if (int'(rd_ptr) - p0 != 2) begin bad++; $display("FAIL b2b_pops: got %0d want 2", int'(rd_ptr) - p0); end
        total++;
        if (pop_cyc[p0+1] - pop_cyc[p0] != 3) begin
            bad++; $display("FAIL b2b_pop_gap: got %0d want 3", pop_cyc[p0+1] - pop_cyc[p0]);
        end
        total++;
        if (nb != 10) begin bad++; $display("FAIL b2b_busy: got %0d want 10", nb); end
        total++;
        if (ns - s0 != 2) begin bad++; $display("FAIL b2b_syncs: got %0d want 2", ns - s0); end
        else begin
            total++;
            if (sync_cyc[s0+1] - sync_cyc[s0] != 3) begin
                bad++; $display("FAIL b2b_sync_gap: got %0d want 3", sync_cyc[s0+1] - sync_cyc[s0]);
            end
            total++;
            if (sync_outsel[s0] !== 2'd1 || sync_outsel[s0+1] !== 2'd3) begin
                bad++; $display("FAIL b2b_outsel: got %0d %0d want 1 3", sync_outsel[s0], sync_outsel[s0+1]);
            end
            total++;
            if (ph(sync_dds[s0], 1) !== 32'h1010 || ph(sync_dds[s0+1], 1) !== 32'h20) begin
                bad++; $display("FAIL b2b_lane1: got %0h %0h want 1010 20", ph(sync_dds[s0], 1), ph(sync_dds[s0+1], 1));
            end
            total++;
            if (pi(sync_dds[s0+1], 0) !== 32'h200) begin
                bad++; $display("FAIL b2b_pinc: got %0h want 200", pi(sync_dds[s0+1], 0));
            end
        end
    endtask

    task automatic test_repeat();
        int p0 = int'(rd_ptr);
        int s0 = ns;
        push(mk(1'b1, 1'b1, 2'd1, 16'd4, 32'h0, 32'h40));
        repeat (15) @(negedge clk);
        push(mk(1'b0, 1'b1, 2'd2, 16'd2, 32'h0, 32'h80));
        repeat (12) @(negedge clk);
        #1;
        total++;
        if (int'(rd_ptr) - p0 != 2) begin bad++; $display("FAIL rep_pops: got %0d want 2", int'(rd_ptr) - p0); end
        total++;
        if (pop_cyc[p0+1] - pop_cyc[p0] != 16) begin
            bad++; $display("FAIL rep_boundary: got %0d want 16", pop_cyc[p0+1] - pop_cyc[p0]);
        end
        total++;
        if (ns - s0 != 5) begin bad++; $display("FAIL rep_syncs: got %0d want 5", ns - s0); end
        else begin
            for (int k = 1; k < 5; k++) begin
                total++;
                if (sync_cyc[s0+k] - sync_cyc[s0+k-1] != 4) begin
                    bad++; $display("FAIL rep_period%0d: got %0d want 4", k, sync_cyc[s0+k] - sync_cyc[s0+k-1]);
                end
            end
            total++;
            if (sync_outsel[s0+3] !== 2'd1 || sync_outsel[s0+4] !== 2'd2) begin
                bad++; $display("FAIL rep_outsel: got %0d %0d want 1 2", sync_outsel[s0+3], sync_outsel[s0+4]);
            end
            total++;
            if (sync_cyc[s0+4] - pop_cyc[p0+1] != 4 || pi(sync_dds[s0+4], 0) !== 32'h800) begin
                bad++; $display("FAIL rep_new_word: lat=%0d pinc=%0h want 4 800",
                                sync_cyc[s0+4] - pop_cyc[p0+1], pi(sync_dds[s0+4], 0));
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rep_stop: busy=%0b want 0", busy); end
    endtask

    task automatic test_coherent();
        int p0 = int'(rd_ptr);
        int s0 = ns;
        logic [31:0] t0;
        push(mk(1'b0, 1'b0, 2'd0, 16'd3, 32'hFFFFFF00, 32'h10000001));
        repeat (10) @(negedge clk);
        #1;
        // t0 is a multiple of 16, so 0x10000001*t0 reduces to t0 mod 2^32
        t0 = pop_cn[p0];
        total++;
        if (ns - s0 != 1) begin bad++; $display("FAIL coh_syncs: got %0d want 1", ns - s0); end
        else begin
            total++;
            if (ph(sync_dds[s0], 0) !== 32'hFFFFFF00 + t0) begin
                bad++; $display("FAIL coh_lane0: got %0h want %0h", ph(sync_dds[s0], 0), 32'hFFFFFF00 + t0);
            end
            total++;
            if (ph(sync_dds[s0], 15) !== 32'hFFFFFF00 + t0 + 32'hF000000F) begin
                bad++; $display("FAIL coh_lane15: got %0h want %0h", ph(sync_dds[s0], 15),
                                32'hFFFFFF00 + t0 + 32'hF000000F);
            end
            total++;
            if (pi(sync_dds[s0], 7) !== 32'h10) begin
                bad++; $display("FAIL coh_pinc: got %0h want 10", pi(sync_dds[s0], 7));
            end
`ifdef READOUT_CTRL_TSTAMP_EN
            total++;
            if (sync_ts[s0] !== t0) begin
                bad++; $display("FAIL coh_tstamp: got %0h want %0h", sync_ts[s0], t0);
            end
`endif
        end
    endtask

    task automatic test_nsamp0();
        int p0 = int'(rd_ptr);
        int s0 = ns;
        int nb = 0;
        push(mk(1'b0, 1'b1, 2'd3, 16'd0, 32'h0, 32'h5));
        repeat (8) begin
            @(negedge clk);
            if (busy) nb++;
        end
        #1;
        total++;
        if (nb != 1 || int'(rd_ptr) - p0 != 1) begin
            bad++; $display("FAIL n0_duration: busy=%0d pops=%0d want 1 1", nb, int'(rd_ptr) - p0);
        end
        total++;
        if (ns - s0 != 1) begin bad++; $display("FAIL n0_syncs: got %0d want 1", ns - s0); end
        else begin
            total++;
            if (sync_outsel[s0] !== 2'd3 || ph(sync_dds[s0], 2) !== 32'hA || pi(sync_dds[s0], 2) !== 32'h50) begin
                bad++; $display("FAIL n0_word: outsel=%0d ph2=%0h pinc=%0h want 3 a 50",
                                sync_outsel[s0], ph(sync_dds[s0], 2), pi(sync_dds[s0], 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0 = int'(rd_ptr);
        push(mk(1'b1, 1'b1, 2'd1, 16'd40, 32'h0, 32'h7));
        repeat (8) @(negedge clk);
        total++;
        if (busy !== 1'b1 || pi(dds_ctrl, 0) !== 32'h70) begin
            bad++; $display("FAIL mid_pre: busy=%0b pinc=%0h want 1 70", busy, pi(dds_ctrl, 0));
        end
        push(mk(1'b0, 1'b1, 2'd2, 16'd20, 32'h0, 32'h9));
        rst = 1'b1;
        #1;
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got %0b want 0", fifo_rd_en); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || dds_ctrl !== '0 || outsel !== 2'd0) begin
            bad++; $display("FAIL mid_clear: busy=%0b dds_nz=%0b outsel=%0d want 0 0 0", busy, |dds_ctrl, outsel);
        end
        repeat (2) @(negedge clk);
        total++;
        if (int'(rd_ptr) - p0 != 1) begin bad++; $display("FAIL mid_no_pop: got %0d want 1", int'(rd_ptr) - p0); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (int'(rd_ptr) - p0 != 2 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_resume: pops=%0d busy=%0b want 2 1", int'(rd_ptr) - p0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_repeat();
        test_coherent();
        test_nsamp0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
